sad_disparity_engine: RTL and testbench

//  Parametrised block-matching stereo engine. Loads a left then a right 8-bit greyscale frame

---
 rtl/sad_disparity_engine_if.sv | 38 +++
 rtl/sad_disparity_engine.sv | 232 +++++++++++++++++++++++
 tb/tb_sad_disparity_engine.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/sad_disparity_engine_if.sv
// sad_disparity_engine_if
//   Groups the control, pixel-stream and result-read signals of the
//   stereo block-matching engine.
//   Signals:
//     start      begin a new frame pair (source -> engine)
//     pix_in     8-bit pixel, raster order, left frame then right frame
//     pix_valid  pix_in valid (source -> engine)
//     pix_ready  engine accepts a pixel this cycle (engine -> source)
//     busy       engine is loading or matching
//     done       one-cycle pulse when the disparity map is complete
//     rd_x/rd_y  result read coordinates (reader -> engine)
//     rd_data    disparity at (rd_x,rd_y), one cycle after the address
//   Modports: master = frame source / display side, slave = engine.
interface sad_disparity_engine_if #(
   parameter int WIDTH  = 20,
   parameter int HEIGHT = 7,
   parameter int DISP_W = 4
);
   logic                      start;
   logic [7:0]                pix_in;
   logic                      pix_valid;
   logic                      pix_ready;
   logic                      busy;
   logic                      done;
   logic [$clog2(WIDTH)-1:0]  rd_x;
   logic [$clog2(HEIGHT)-1:0] rd_y;
   logic [DISP_W-1:0]         rd_data;

   modport master (
      output start, pix_in, pix_valid, rd_x, rd_y,
      input  pix_ready, busy, done, rd_data
   );

   modport slave (
      input  start, pix_in, pix_valid, rd_x, rd_y,
      output pix_ready, busy, done, rd_data
   );
endinterface

// File: rtl/sad_disparity_engine.sv
// sad_disparity_engine
//   Block-matching stereo engine. A left then a right greyscale frame are
//   streamed in over a valid/ready handshake and stored in two frame RAMs.
//   For each output pixel the sum of absolute differences over a BLK x BLK
//   window is evaluated for every disparity d with x-d >= 0, one pixel
//   difference per cycle, and the lowest-cost d (lowest d on ties) is
//   stored in the result RAM, which is readable at any time.
//   Ports:
//     clk    system clock
//     reset  asynchronous, active-high reset
//     bus    sad_disparity_engine_if.slave (stream, status, result read)
module sad_disparity_engine #(
   parameter int WIDTH    = 20,
   parameter int HEIGHT   = 7,
   parameter int HALF_BLK = 2,
   parameter int MAX_DISP = 15,
   parameter int DISP_W   = 4
) (
   input  logic                   clk,
   input  logic                   reset,
   sad_disparity_engine_if.slave  bus
);
   localparam int BLK   = 2*HALF_BLK + 1;
   localparam int NPIX  = WIDTH*HEIGHT;
   localparam int SAD_W = 8 + $clog2(BLK*BLK);
   localparam int AW    = $clog2(NPIX);
   localparam int XW    = $clog2(WIDTH);
   localparam int YW    = $clog2(HEIGHT);
   localparam int BW    = $clog2(BLK+1);

   typedef enum logic [2:0] {IDLE, LOAD_L, LOAD_R, MATCH, UPDATE, DONE} state_t;

   state_t              state_reg;
   logic [AW-1:0]       addr_reg;
   logic [XW-1:0]       x_reg;
   logic [YW-1:0]       y_reg;
   logic [DISP_W-1:0]   d_reg;
   logic [BW-1:0]       i_reg;
   logic [BW-1:0]       j_reg;
   logic [SAD_W-1:0]    acc_reg;
   logic [SAD_W-1:0]    best_sad_reg;
   logic [DISP_W-1:0]   best_d_reg;
   logic                pix_ready_reg;
   logic                busy_reg;
   logic                done_reg;
   logic [DISP_W-1:0]   rd_data_reg;
   logic [7:0]          l_q_reg;
   logic [7:0]          r_q_reg;

   logic [7:0]          left_mem  [NPIX];
   logic [7:0]          right_mem [NPIX];
   logic [DISP_W-1:0]   res_mem   [NPIX];

   logic                xfer;
   logic                load_l_wr;
   logic                load_r_wr;
   logic                last_elem;
   logic                last_d;
   logic                new_best;
   logic                res_wr;
   logic [7:0]          abs_diff;
   logic [SAD_W-1:0]    sad_total;
   logic [DISP_W-1:0]   best_d_next;
   logic [AW-1:0]       l_rd_addr;
   logic [AW-1:0]       r_rd_addr;
   logic [AW-1:0]       res_wr_addr;
   logic [AW-1:0]       rd_addr;
   int                  row;
   int                  l_col;
   int                  r_col;

   assign xfer      = bus.pix_valid & pix_ready_reg;
   assign load_l_wr = (state_reg == LOAD_L) && xfer;
   assign load_r_wr = (state_reg == LOAD_R) && xfer;
   assign last_elem = (i_reg == BW'(BLK-1)) && (j_reg == BW'(BLK-1));
   // Candidates stop at min(x, MAX_DISP-1); larger d would index left of column 0.
   assign last_d    = (int'(d_reg) == MAX_DISP-1) || (int'(d_reg) == int'(x_reg));

   // Window addressing with edge replication; the right-frame column is
   // clamped after the disparity shift, not before.
   always_comb begin
      row   = int'(y_reg) + int'(j_reg) - HALF_BLK;
      l_col = int'(x_reg) + int'(i_reg) - HALF_BLK;
      r_col = l_col - int'(d_reg);
      if (row < 0)        row   = 0;
      if (row > HEIGHT-1) row   = HEIGHT-1;
      if (l_col < 0)      l_col = 0;
      if (l_col > WIDTH-1) l_col = WIDTH-1;
      if (r_col < 0)      r_col = 0;
      if (r_col > WIDTH-1) r_col = WIDTH-1;
      l_rd_addr   = AW'(row*WIDTH + l_col);
      r_rd_addr   = AW'(row*WIDTH + r_col);
      res_wr_addr = AW'(int'(y_reg)*WIDTH + int'(x_reg));
      rd_addr     = AW'(int'(bus.rd_y)*WIDTH + int'(bus.rd_x));
   end

   // Frame RAM data lags the address by one cycle, so the difference used in
   // a given cycle belongs to the window element addressed the cycle before.
   // The final element of a window is therefore added during UPDATE.
   always_comb begin
      abs_diff    = (l_q_reg > r_q_reg) ? (l_q_reg - r_q_reg) : (r_q_reg - l_q_reg);
      sad_total   = acc_reg + SAD_W'(abs_diff);
      new_best    = (d_reg == '0) || (sad_total < best_sad_reg);
      best_d_next = new_best ? d_reg : best_d_reg;
      res_wr      = (state_reg == UPDATE) && last_d;
   end

   always_ff @(posedge clk) begin
      if (load_l_wr) left_mem[addr_reg] <= bus.pix_in;
      l_q_reg <= left_mem[l_rd_addr];
   end

   always_ff @(posedge clk) begin
      if (load_r_wr) right_mem[addr_reg] <= bus.pix_in;
      r_q_reg <= right_mem[r_rd_addr];
   end

   always_ff @(posedge clk) begin
      if (res_wr) res_mem[res_wr_addr] <= best_d_next;
   end

   // Read sits in its own process so a same-cycle write returns the old value.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) rd_data_reg <= '0;
      else       rd_data_reg <= res_mem[rd_addr];
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg     <= IDLE;
         addr_reg      <= '0;
         x_reg         <= '0;
         y_reg         <= '0;
         d_reg         <= '0;
         i_reg         <= '0;
         j_reg         <= '0;
         acc_reg       <= '0;
         best_sad_reg  <= '0;
         best_d_reg    <= '0;
         pix_ready_reg <= 1'b0;
         busy_reg      <= 1'b0;
         done_reg      <= 1'b0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (bus.start) begin
                  state_reg     <= LOAD_L;
                  addr_reg      <= '0;
                  busy_reg      <= 1'b1;
                  pix_ready_reg <= 1'b1;
               end
            end
            LOAD_L: begin
               if (xfer) begin
                  if (addr_reg == AW'(NPIX-1)) begin
                     addr_reg  <= '0;
                     state_reg <= LOAD_R;
                  end else begin
                     addr_reg <= addr_reg + AW'(1);
                  end
               end
            end
            LOAD_R: begin
               if (xfer) begin
                  if (addr_reg == AW'(NPIX-1)) begin
                     addr_reg      <= '0;
                     pix_ready_reg <= 1'b0;
                     state_reg     <= MATCH;
                     x_reg         <= '0;
                     y_reg         <= '0;
                     d_reg         <= '0;
                     i_reg         <= '0;
                     j_reg         <= '0;
                  end else begin
                     addr_reg <= addr_reg + AW'(1);
                  end
               end
            end
            MATCH: begin
               // First cycle of a window has no valid RAM data yet.
               if (i_reg == '0 && j_reg == '0) acc_reg <= '0;
               else                            acc_reg <= sad_total;
               if (last_elem) begin
                  i_reg     <= '0;
                  j_reg     <= '0;
                  state_reg <= UPDATE;
               end else if (i_reg == BW'(BLK-1)) begin
                  i_reg <= '0;
                  j_reg <= j_reg + BW'(1);
               end else begin
                  i_reg <= i_reg + BW'(1);
               end
            end
            UPDATE: begin
               if (new_best) begin
                  best_sad_reg <= sad_total;
                  best_d_reg   <= d_reg;
               end
               state_reg <= MATCH;
               if (last_d) begin
                  d_reg <= '0;
                  if (x_reg == XW'(WIDTH-1)) begin
                     x_reg <= '0;
                     if (y_reg == YW'(HEIGHT-1)) begin
                        y_reg     <= '0;
                        state_reg <= DONE;
                        done_reg  <= 1'b1;
                        busy_reg  <= 1'b0;
                     end else begin
                        y_reg <= y_reg + YW'(1);
                     end
                  end else begin
                     x_reg <= x_reg + XW'(1);
                  end
               end else begin
                  d_reg <= d_reg + DISP_W'(1);
               end
            end
            DONE: begin
               done_reg  <= 1'b0;
               state_reg <= IDLE;
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

   assign bus.pix_ready = pix_ready_reg;
   assign bus.busy      = busy_reg;
   assign bus.done      = done_reg;
   assign bus.rd_data   = rd_data_reg;
endmodule

// File: tb/tb_sad_disparity_engine.sv
// tb_sad_disparity_engine
//   Directed sequence of frame pairs with random textures, checked against
//   a straightforward per-pixel SAD search model.
module tb_sad_disparity_engine;
   localparam int W     = 12;
   localparam int H     = 5;
   localparam int HB    = 1;
   localparam int MD    = 6;
   localparam int DW    = 3;
   localparam int NPIX  = W*H;
   localparam int BLK   = 2*HB + 1;
   localparam int LIMIT = 20000;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   sad_disparity_engine_if #(.WIDTH(W), .HEIGHT(H), .DISP_W(DW)) bus();

   sad_disparity_engine #(
      .WIDTH(W), .HEIGHT(H), .HALF_BLK(HB), .MAX_DISP(MD), .DISP_W(DW)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int errors = 0;
   int checks = 0;
   logic [7:0] lf [NPIX];
   logic [7:0] rf [NPIX];
   logic [7:0] lf_keep [NPIX];
   logic [7:0] rf_keep [NPIX];
   int exp_map   [NPIX];
   int saved_map [NPIX];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   function automatic int clampi(input int v, input int hi);
      if (v < 0)  return 0;
      if (v > hi) return hi;
      return v;
   endfunction

   // Reference: exhaustive search per pixel, lowest cost wins, ties to lowest d.
   task automatic build_model();
      for (int y = 0; y < H; y++) begin
         for (int x = 0; x < W; x++) begin
            int best;
            int best_d;
            best = 0;
            best_d = 0;
            for (int d = 0; d < MD; d++) begin
               int sad;
               if (x - d < 0) continue;
               sad = 0;
               for (int j = -HB; j <= HB; j++) begin
                  for (int i = -HB; i <= HB; i++) begin
                     int r;
                     int a;
                     r = clampi(y + j, H-1);
                     a = int'(lf[r*W + clampi(x+i, W-1)]) - int'(rf[r*W + clampi(x+i-d, W-1)]);
                     sad += (a < 0) ? -a : a;
                  end
               end
               if (d == 0 || sad < best) begin
                  best = sad;
                  best_d = d;
               end
            end
            exp_map[y*W + x] = best_d;
         end
      end
   endtask

   // mode 0: identical random frames, 1: right = left shifted by 3, 2: flat 0x80
   task automatic gen_frames(input int mode);
      for (int p = 0; p < NPIX; p++) begin
         int x;
         x = p % W;
         case (mode)
            0: begin lf[p] = 8'($urandom_range(255)); rf[p] = lf[p]; end
            2: begin lf[p] = 8'h80; rf[p] = 8'h80; end
            default: lf[p] = 8'($urandom_range(255));
         endcase
      end
      if (mode == 1) begin
         for (int p = 0; p < NPIX; p++) begin
            if ((p % W) + 3 < W) rf[p] = lf[p + 3];
            else                 rf[p] = 8'($urandom_range(255));
         end
      end
   endtask

   function automatic int expected_cycles();
      int c;
      c = 0;
      for (int x = 0; x < W; x++) c += ((x + 1 < MD) ? x + 1 : MD) * (BLK*BLK + 1);
      return 2*NPIX + c*H;
   endfunction

   // Streams both frames; valid stays asserted (with junk) after the frames so
   // surplus acceptance would show up in xfers.
   task automatic run_pair(input int pct, input bit extra_start, input int abort_at,
                           output int cycles, output int xfers, output bit got_done);
      int idx;
      bit xfer_now;
      idx = 0;
      cycles = 0;
      xfers = 0;
      got_done = 1'b0;
      @(negedge clk);
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      while (!got_done && cycles < LIMIT) begin
         if (idx < NPIX)        bus.pix_in = lf[idx];
         else if (idx < 2*NPIX) bus.pix_in = rf[idx - NPIX];
         else                   bus.pix_in = 8'($urandom_range(255));
         bus.pix_valid = (pct >= 100) ? 1'b1 : ($urandom_range(99) < pct);
         bus.start = extra_start && (cycles == NPIX + 5 || cycles == 2*NPIX + 20);
         xfer_now = bus.pix_valid && bus.pix_ready;
         @(negedge clk);
         cycles++;
         if (xfer_now) begin
            idx++;
            xfers++;
         end
         if (abort_at > 0 && cycles == abort_at) begin
            bus.start = 1'b0;
            bus.pix_valid = 1'b0;
            reset = 1'b1;
            #1;
            check("abort_busy", bus.busy, 0);
            check("abort_ready", bus.pix_ready, 0);
            check("abort_done", bus.done, 0);
            @(negedge clk);
            reset = 1'b0;
            return;
         end
         if (bus.done) got_done = 1'b1;
      end
      bus.pix_valid = 1'b0;
      bus.start = 1'b0;
   endtask

   task automatic after_done(input string tag, input int cycles, input int xfers,
                             input bit got_done, input bit check_cycles);
      check({tag, "_done_seen"}, got_done, 1);
      check({tag, "_busy_with_done"}, bus.busy, 0);
      check({tag, "_xfers"}, xfers, 2*NPIX);
      if (check_cycles) check({tag, "_cycles"}, cycles, expected_cycles());
      @(negedge clk);
      check({tag, "_done_pulse"}, bus.done, 0);
      repeat (3) @(negedge clk);
      check({tag, "_idle_busy"}, bus.busy, 0);
      check({tag, "_idle_ready"}, bus.pix_ready, 0);
      check({tag, "_idle_done"}, bus.done, 0);
   endtask

   task automatic read_map(input string tag, input bit shift_chk, input bit cmp_saved, input bit save);
      for (int y = 0; y < H; y++) begin
         for (int x = 0; x < W; x++) begin
            @(negedge clk);
            bus.rd_x = 4'(x);
            bus.rd_y = 3'(y);
            @(negedge clk);
            $display("%s read x=%0d y=%0d disp=%0d model=%0d", tag, x, y, bus.rd_data, exp_map[y*W+x]);
            check($sformatf("%s_map(%0d,%0d)", tag, x, y), bus.rd_data, exp_map[y*W + x]);
            if (shift_chk && x >= 3 + HB && x <= W - 1 - HB - 3)
               check($sformatf("%s_shift3(%0d,%0d)", tag, x, y), bus.rd_data, 3);
            if (cmp_saved)
               check($sformatf("%s_same(%0d,%0d)", tag, x, y), bus.rd_data, saved_map[y*W + x]);
            if (save) saved_map[y*W + x] = int'(bus.rd_data);
         end
      end
   endtask

   initial begin
      int cyc;
      int xf;
      bit gd;
      bus.start = 1'b0;
      bus.pix_valid = 1'b0;
      bus.pix_in = 8'h00;
      bus.rd_x = '0;
      bus.rd_y = '0;
      reset = 1'b1;
      repeat (3) @(negedge clk);
      check("reset_busy", bus.busy, 0);
      check("reset_ready", bus.pix_ready, 0);
      check("reset_done", bus.done, 0);
      check("reset_rd_data", bus.rd_data, 0);
      reset = 1'b0;
      @(negedge clk);

      // 1: identical frames
      gen_frames(0);
      build_model();
      run_pair(100, 1'b0, 0, cyc, xf, gd);
      $display("t1 frame pair: cycles=%0d xfers=%0d done=%0d", cyc, xf, gd);
      after_done("t1", cyc, xf, gd, 1'b1);
      read_map("t1", 1'b0, 1'b0, 1'b0);

      // 2: shift by 3
      gen_frames(1);
      for (int p = 0; p < NPIX; p++) begin lf_keep[p] = lf[p]; rf_keep[p] = rf[p]; end
      build_model();
      run_pair(100, 1'b0, 0, cyc, xf, gd);
      $display("t2 frame pair: cycles=%0d xfers=%0d done=%0d", cyc, xf, gd);
      after_done("t2", cyc, xf, gd, 1'b1);
      read_map("t2", 1'b1, 1'b0, 1'b1);

      // 3: flat frames, all ties
      gen_frames(2);
      build_model();
      run_pair(100, 1'b0, 0, cyc, xf, gd);
      $display("t3 frame pair: cycles=%0d xfers=%0d done=%0d", cyc, xf, gd);
      after_done("t3", cyc, xf, gd, 1'b1);
      read_map("t3", 1'b0, 1'b0, 1'b0);

      // 4: test 2 data with 50% valid duty
      for (int p = 0; p < NPIX; p++) begin lf[p] = lf_keep[p]; rf[p] = rf_keep[p]; end
      build_model();
      run_pair(50, 1'b0, 0, cyc, xf, gd);
      $display("t4 frame pair: cycles=%0d xfers=%0d done=%0d", cyc, xf, gd);
      after_done("t4", cyc, xf, gd, 1'b0);
      read_map("t4", 1'b1, 1'b1, 1'b0);

      // 5: reset during MATCH, then a clean full pass
      run_pair(100, 1'b0, 2*NPIX + 40, cyc, xf, gd);
      $display("t5 aborted pair: cycles=%0d xfers=%0d", cyc, xf);
      run_pair(100, 1'b0, 0, cyc, xf, gd);
      $display("t5 frame pair: cycles=%0d xfers=%0d done=%0d", cyc, xf, gd);
      after_done("t5", cyc, xf, gd, 1'b1);
      read_map("t5", 1'b1, 1'b1, 1'b0);

      // 6: stray start pulses during LOAD_R and MATCH
      run_pair(100, 1'b1, 0, cyc, xf, gd);
      $display("t6 frame pair: cycles=%0d xfers=%0d done=%0d", cyc, xf, gd);
      after_done("t6", cyc, xf, gd, 1'b1);
      read_map("t6", 1'b1, 1'b1, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
